// File: rtl/leaf_switch_pkg.sv
// Shared definitions for the leaf switch: header field positions, port indices,
// and the routing/arbitration helpers used by the switch core.
package leaf_switch_pkg;

    localparam int NUM_PORTS = 5;
    localparam int NUM_LOCAL = 4;
    localparam int UP_PORT   = 4;

    localparam logic [3:0] INVALID_GROUP = 4'd0;

    localparam int GROUP_MSB   = 15;
    localparam int GROUP_LSB   = 12;
    localparam int LEAF_MSB    = 11;
    localparam int LEAF_LSB    = 10;
    localparam int PAYLOAD_MSB = 9;

    typedef logic [2:0] port_idx_t;

    typedef struct packed {
        logic      drop;
        port_idx_t dest;
    } route_t;

    typedef struct packed {
        logic      valid;
        port_idx_t idx;
    } grant_t;

    function automatic route_t route_flit(input logic [GROUP_MSB:0] flit,
                                          input logic               from_uplink,
                                          input logic [3:0]         group_id);
        route_t     r;
        logic [3:0] grp;
        grp    = flit[GROUP_MSB:GROUP_LSB];
        r.drop = 1'b0;
        r.dest = {1'b0, flit[LEAF_MSB:LEAF_LSB]};
        if (grp == INVALID_GROUP) begin
            r.drop = 1'b1;
        end else if (grp != group_id) begin
            // Foreign groups climb the tree; coming down with a foreign group is a dead end.
            if (from_uplink) r.drop = 1'b1;
            else             r.dest = port_idx_t'(UP_PORT);
        end
        return r;
    endfunction

    // Scans downward so the lowest offset from ptr is the last, winning write.
    function automatic grant_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                       input port_idx_t            ptr);
        grant_t g;
        int     idx;
        g = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) idx -= NUM_PORTS;
            if (req[idx]) begin
                g.valid = 1'b1;
                g.idx   = port_idx_t'(idx);
            end
        end
        return g;
    endfunction

    function automatic port_idx_t next_port(input port_idx_t idx);
        return (idx == port_idx_t'(NUM_PORTS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Per-input flit FIFO: power-of-two depth, occupancy-count based full/empty,
// pushes while full are ignored (the owner counts them as drops).
module flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       head_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign empty     = (count == '0);
    assign full      = (count == (AW + 1)'(DEPTH));
    assign head_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leaf_switch.sv
// Leaf switch of the tree NoC: four local NI ports plus one uplink, each buffered
// by a flit_fifo, routed by header group/leaf and arbitrated round-robin per output.
module leaf_switch
    import leaf_switch_pkg::*;
#(
    parameter int GROUP_ID   = 1,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DATA_W-1:0]   loc_in_data,
    input  logic [3:0]            loc_in_valid,
    output logic [3:0]            loc_in_ready,
    output logic [4*DATA_W-1:0]   loc_out_data,
    output logic [3:0]            loc_out_valid,
    input  logic [DATA_W-1:0]     up_in_data,
    input  logic                  up_in_valid,
    output logic                  up_in_ready,
    output logic [DATA_W-1:0]     up_out_data,
    output logic                  up_out_valid,
    input  logic                  up_out_ready,
    output logic [7:0]            drop_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]    in_data    [NUM_PORTS];
    logic [DATA_W-1:0]    head       [NUM_PORTS];
    logic [CNT_W-1:0]     fifo_count [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_valid;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_pop;
    logic [NUM_PORTS-1:0] route_drop;
    logic [NUM_PORTS-1:0] req        [NUM_PORTS];
    route_t               rt         [NUM_PORTS];
    grant_t               gnt        [NUM_PORTS];
    port_idx_t            rr_ptr     [NUM_PORTS];
    logic                 up_slot_free;
    logic [3:0]           drop_sum;
    logic [8:0]           drop_next;

    assign in_valid    = {up_in_valid, loc_in_valid};
    assign in_data[UP_PORT] = up_in_data;
    assign up_in_ready = !fifo_full[UP_PORT];

    for (genvar i = 0; i < NUM_LOCAL; i++) begin : g_local
        assign in_data[i] = loc_in_data[i*DATA_W +: DATA_W];
        // Two free slots absorb the flit an NI may still launch in the cycle after ready drops.
        assign loc_in_ready[i] = (fifo_count[i] <= CNT_W'(FIFO_DEPTH - 2));
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        flit_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (in_valid[i]),
            .push_data (in_data[i]),
            .pop       (fifo_pop[i]),
            .head_data (head[i]),
            .empty     (fifo_empty[i]),
            .full      (fifo_full[i]),
            .count     (fifo_count[i])
        );
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        route_drop = '0;
        for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rt[i] = route_flit(head[i][GROUP_MSB:0], (i == UP_PORT), 4'(GROUP_ID));
            if (!fifo_empty[i]) begin
                if (rt[i].drop) begin
                    route_drop[i] = 1'b1;
                end else begin
                    for (int o = 0; o < NUM_PORTS; o++) begin
                        if (rt[i].dest == port_idx_t'(o)) req[o][i] = 1'b1;
                    end
                end
            end
        end
    end

    assign up_slot_free = !up_out_valid || up_out_ready;

    // Each head has a single destination, so grants across outputs never collide on an input.
    always_comb begin
        fifo_pop = route_drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            gnt[o] = rr_pick(req[o], rr_ptr[o]);
            if (o == UP_PORT && !up_slot_free) gnt[o].valid = 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt[o].valid && gnt[o].idx == port_idx_t'(i)) fifo_pop[i] = 1'b1;
            end
        end
    end

    assign drop_sum  = 4'($countones(in_valid & fifo_full)) + 4'($countones(route_drop));
    assign drop_next = {1'b0, drop_count} + 9'(drop_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < NUM_PORTS; o++) rr_ptr[o] <= '0;
            loc_out_valid <= '0;
            loc_out_data  <= '0;
            up_out_valid  <= 1'b0;
            up_out_data   <= '0;
            drop_count    <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (gnt[o].valid) rr_ptr[o] <= next_port(gnt[o].idx);
            end
            for (int o = 0; o < NUM_LOCAL; o++) begin
                loc_out_valid[o] <= gnt[o].valid;
                if (gnt[o].valid) loc_out_data[o*DATA_W +: DATA_W] <= head[gnt[o].idx];
            end
            if (gnt[UP_PORT].valid) begin
                up_out_valid <= 1'b1;
                up_out_data  <= head[gnt[UP_PORT].idx];
            end else if (up_out_ready) begin
                up_out_valid <= 1'b0;
            end
            drop_count <= drop_next[8] ? 8'hFF : drop_next[7:0];
        end
    end

endmodule

// File: tb/tb_leaf_switch.sv
// Directed and randomized bench for leaf_switch; random traffic is checked against
// per (source, destination) expectation queues and a drop tally.
module tb_leaf_switch;

    localparam int GROUP_ID   = 1;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [4*DATA_W-1:0] loc_in_data;
    logic [3:0]          loc_in_valid;
    logic [3:0]          loc_in_ready;
    logic [4*DATA_W-1:0] loc_out_data;
    logic [3:0]          loc_out_valid;
    logic [DATA_W-1:0]   up_in_data;
    logic                up_in_valid;
    logic                up_in_ready;
    logic [DATA_W-1:0]   up_out_data;
    logic                up_out_valid;
    logic                up_out_ready;
    logic [7:0]          drop_count;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q [5][5][$];
    int          exp_drops;
    int          seq;
    logic        up_hold_pending;
    logic [15:0] up_hold_data;
    logic [3:0]  prev_rdy;

    leaf_switch #(
        .GROUP_ID   (GROUP_ID),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .loc_in_data   (loc_in_data),
        .loc_in_valid  (loc_in_valid),
        .loc_in_ready  (loc_in_ready),
        .loc_out_data  (loc_out_data),
        .loc_out_valid (loc_out_valid),
        .up_in_data    (up_in_data),
        .up_in_valid   (up_in_valid),
        .up_in_ready   (up_in_ready),
        .up_out_data   (up_out_data),
        .up_out_valid  (up_out_valid),
        .up_out_ready  (up_out_ready),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_loc(input int port, input logic [15:0] d);
        loc_in_data[port*16 +: 16] = d;
        loc_in_valid[port]         = 1'b1;
    endtask

    task automatic sb_pop(input int s, input int o, input logic [15:0] d);
        logic [15:0] e;
        check("sb_src_range", 32'(s <= 4), 32'd1);
        if (s <= 4) begin
            check($sformatf("sb_expected_%0d_%0d", s, o), 32'(exp_q[s][o].size() > 0), 32'd1);
            if (exp_q[s][o].size() > 0) begin
                e = exp_q[s][o].pop_front();
                check($sformatf("sb_order_%0d_%0d", s, o), 32'(d), 32'(e));
            end
        end
    endtask

    // Call after up_out_ready has been driven for the current cycle.
    task automatic observe();
        for (int o = 0; o < 4; o++) begin
            if (loc_out_valid[o]) sb_pop(int'(loc_out_data[o*16+7 +: 3]), o, loc_out_data[o*16 +: 16]);
        end
        if (up_hold_pending) begin
            check("up_hold_valid", 32'(up_out_valid), 32'd1);
            check("up_hold_data", 32'(up_out_data), 32'(up_hold_data));
        end
        up_hold_pending = 1'b0;
        if (up_out_valid) begin
            if (up_out_ready) begin
                sb_pop(int'(up_out_data[9:7]), 4, up_out_data);
            end else begin
                up_hold_pending = 1'b1;
                up_hold_data    = up_out_data;
            end
        end
    endtask

    task automatic sb_all_empty(input string tag);
        for (int s = 0; s < 5; s++)
            for (int d = 0; d < 5; d++)
                check($sformatf("%s_left_%0d_%0d", tag, s, d), 32'(exp_q[s][d].size()), 32'd0);
    endtask

    function automatic logic [15:0] make_flit(input int src, input int n);
        int         r;
        logic [3:0] grp;
        r = int'($urandom_range(7, 0));
        if (r == 0)      grp = 4'd0;
        else if (r <= 4) grp = 4'(GROUP_ID);
        else if (r == 5) grp = 4'd2;
        else             grp = 4'd9;
        return {grp, 2'($urandom_range(3, 0)), 3'(src), 7'(n)};
    endfunction

    // Destination per the routing rules, expressed directly on header fields.
    task automatic model_route(input int src, input logic [15:0] d);
        if (d[15:12] == 4'd0)                   exp_drops++;
        else if (d[15:12] == 4'(GROUP_ID))      exp_q[src][int'(d[11:10])].push_back(d);
        else if (src == 4)                      exp_drops++;
        else                                    exp_q[src][4].push_back(d);
    endtask

    initial begin
        logic [15:0] d;
        int          sent0;
        logic        prev0;
        logic        saw_low;

        reset        = 1'b1;
        loc_in_data  = '0;
        loc_in_valid = '0;
        up_in_data   = '0;
        up_in_valid  = 1'b0;
        up_out_ready = 1'b0;
        up_hold_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        check("rst_loc_in_ready", 32'(loc_in_ready), 32'hF);
        check("rst_up_in_ready", 32'(up_in_ready), 32'd1);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_loc_out_valid", 32'(loc_out_valid), 32'd0);
        check("rst_up_out_valid", 32'(up_out_valid), 32'd0);
        check("rst_loc_out_data", loc_out_data[31:0], 32'd0);
        check("rst_loc_out_data_hi", loc_out_data[63:32], 32'd0);
        check("rst_up_out_data", 32'(up_out_data), 32'd0);

        // Single local flit, group 1 leaf 3.
        set_loc(0, 16'h1C05);
        tick();
        loc_in_valid = '0;
        check("single_not_early", 32'(loc_out_valid), 32'd0);
        tick();
        check("single_valid", 32'(loc_out_valid), 32'h8);
        check("single_data", 32'(loc_out_data[63:48]), 32'h1C05);
        tick();
        check("single_pulse_once", 32'(loc_out_valid), 32'd0);
        check("single_no_drop", 32'(drop_count), 32'd0);

        // Foreign group to uplink under backpressure.
        set_loc(1, 16'h2012);
        tick();
        loc_in_valid = '0;
        check("up_not_early", 32'(up_out_valid), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("up_stall_valid", 32'(up_out_valid), 32'd1);
            check("up_stall_data", 32'(up_out_data), 32'h2012);
            tick();
        end
        up_out_ready = 1'b1;
        check("up_before_xfer", 32'(up_out_valid), 32'd1);
        tick();
        check("up_after_xfer", 32'(up_out_valid), 32'd0);
        tick();
        check("up_single_xfer", 32'(up_out_valid), 32'd0);

        // Three inputs contending for leaf 2.
        set_loc(0, 16'h1800);
        set_loc(1, 16'h1801);
        set_loc(2, 16'h1802);
        tick();
        loc_in_valid = '0;
        check("rr_not_early", 32'(loc_out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rr_valid_%0d", k), 32'(loc_out_valid), 32'h4);
            check($sformatf("rr_data_%0d", k), 32'(loc_out_data[47:32]), 32'h1800 + 32'(k));
        end
        tick();
        check("rr_done", 32'(loc_out_valid), 32'd0);

        // Uplink arrivals that cannot be delivered.
        up_in_data  = 16'h3000;
        up_in_valid = 1'b1;
        tick();
        up_in_data  = 16'h0005;
        tick();
        up_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("updrop_no_loc", 32'(loc_out_valid), 32'd0);
            check("updrop_no_up", 32'(up_out_valid), 32'd0);
            tick();
        end
        check("updrop_count", 32'(drop_count), 32'd2);

        // Burst on port 0 while ports 1 and 2 compete for leaf 3; port 0 acts like an NI
        // that reacts to ready one cycle late.
        up_hold_pending = 1'b0;
        sent0   = 0;
        prev0   = loc_in_ready[0];
        saw_low = 1'b0;
        for (int c = 0; c < 60; c++) begin
            loc_in_valid = '0;
            if (c < 3) begin
                for (int p = 1; p <= 2; p++) begin
                    d = {6'b000111, 3'(p), 7'(c)};
                    set_loc(p, d);
                    exp_q[p][3].push_back(d);
                end
            end
            if (sent0 < 6 && prev0) begin
                d = {6'b000111, 3'd0, 7'(sent0)};
                set_loc(0, d);
                exp_q[0][3].push_back(d);
                sent0++;
            end
            prev0 = loc_in_ready[0];
            if (!loc_in_ready[0]) saw_low = 1'b1;
            observe();
            tick();
        end
        loc_in_valid = '0;
        check("burst_all_sent", 32'(sent0), 32'd6);
        check("burst_ready_fell", 32'(saw_low), 32'd1);
        check("burst_no_drop", 32'(drop_count), 32'd2);
        sb_all_empty("burst");

        // Reset while flits are buffered and one sits in the uplink register.
        up_out_ready = 1'b0;
        set_loc(0, 16'h2000);
        set_loc(1, 16'h2001);
        set_loc(2, 16'h2002);
        tick();
        loc_in_valid = '0;
        tick();
        tick();
        check("prerst_up_valid", 32'(up_out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_up_valid", 32'(up_out_valid), 32'd0);
        check("midrst_up_data", 32'(up_out_data), 32'd0);
        check("midrst_loc_valid", 32'(loc_out_valid), 32'd0);
        check("midrst_loc_data", loc_out_data[63:32], 32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        tick();
        tick();
        reset        = 1'b0;
        up_out_ready = 1'b1;
        tick();
        check("postrst_loc_in_ready", 32'(loc_in_ready), 32'hF);
        check("postrst_up_in_ready", 32'(up_in_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("postrst_no_up", 32'(up_out_valid), 32'd0);
            check("postrst_no_loc", 32'(loc_out_valid), 32'd0);
            tick();
        end

        // Randomized traffic against the queue model.
        exp_drops       = 0;
        seq             = 0;
        up_hold_pending = 1'b0;
        prev_rdy        = loc_in_ready;
        for (int c = 0; c < 600; c++) begin
            loc_in_valid = '0;
            up_in_valid  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (prev_rdy[i] && $urandom_range(1, 0) == 1) begin
                    d = make_flit(i, seq);
                    set_loc(i, d);
                    model_route(i, d);
                    seq++;
                end
            end
            if (up_in_ready && $urandom_range(1, 0) == 1) begin
                d = make_flit(4, seq);
                up_in_data  = d;
                up_in_valid = 1'b1;
                model_route(4, d);
                seq++;
            end
            up_out_ready = ($urandom_range(3, 0) != 0);
            prev_rdy     = loc_in_ready;
            observe();
            tick();
        end
        loc_in_valid = '0;
        up_in_valid  = 1'b0;
        up_out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            observe();
            tick();
        end
        sb_all_empty("rand");
        check("rand_drop_count", 32'(drop_count), (exp_drops > 255) ? 32'd255 : 32'(exp_drops));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leaf_switch.md
LEAF_SWITCH -- requirements
Module: leaf_switch

Interface
REQ-001 SHALL have parameter GROUP_ID, default 1: 4-bit group field owned by this switch; legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 16: flit width; header is bits [15:10], group [15:12], leaf [11:10], payload [9:0].
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: per-input FIFO depth, power of two, at least 2.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 loc_in_data  input  4*DATA_W  flits from the four NIs; port i occupies [i*16+:16], i = leaf index.
REQ-007 loc_in_valid  input  4  one-cycle flit strobe per local port.
REQ-008 loc_in_ready  output  4  per-port permission to send; wired to the NI router_ready_in.
REQ-009 loc_out_data  output  4*DATA_W  flits to the four NIs.
REQ-010 loc_out_valid  output  4  one-cycle strobe per local port; no backpressure exists on this path.
REQ-011 up_in_data / up_in_valid / up_in_ready  in/in/out  16/1/1  flits from the upper tree level.
REQ-012 up_out_data / up_out_valid / up_out_ready  out/out/in  16/1/1  flits to the upper tree level, valid/ready.
REQ-013 drop_count  output  8  saturating count of discarded flits.

Function
REQ-014 Each of the 5 inputs (local 0..3 = index 0..3, uplink = index 4) SHALL own a FIFO_DEPTH flit FIFO; valid=1 writes the flit at the edge.
REQ-015 loc_in_ready[i] SHALL be 1 iff FIFO i has >=2 free slots, covering the NI one-cycle-late valid after ready; up_in_ready SHALL be 1 iff FIFO 4 has >=1 free slot.
REQ-016 A write arriving while the FIFO is full SHALL be discarded and SHALL increment drop_count.
REQ-017 Routing of a head flit: group==0 -> drop; group==GROUP_ID -> local output [11:10]; other group from local input -> uplink; other group from uplink input -> drop.
REQ-018 Every drop SHALL increment drop_count by 1, saturating at 255. Simultaneous drops in one cycle SHALL add their sum, saturating.
REQ-019 Each output SHALL run an independent round-robin arbiter over requesting inputs 0..4; the pointer SHALL advance to one past the granted input; it SHALL reset to 0.
REQ-020 Local outputs SHALL accept a grant every cycle: the flit is registered to loc_out_data and loc_out_valid pulses 1 for exactly one cycle; otherwise valid=0 and data holds.
REQ-021 Uplink output SHALL be a one-entry register: a grant is allowed when empty or when up_out_ready=1 in the same cycle. Data and valid SHALL hold stable while valid=1 and ready=0.
REQ-022 A granted flit SHALL be popped from its FIFO in the grant cycle; a simultaneous push and pop on one FIFO SHALL keep the count unchanged.
REQ-023 Uncontended latency: flit written at edge E SHALL appear on its output after edge E+1.
REQ-024 Flits are forwarded unmodified; per input-output pair, order SHALL be preserved.
REQ-025 Pointer wrap SHALL be modulo FIFO_DEPTH; full and empty SHALL be derived from an occupancy count of width log2(FIFO_DEPTH)+1.

Reset
REQ-026 Reset SHALL clear all FIFO pointers and counts, arbiter pointers, drop_count, loc_out_valid, up_out_valid, loc_out_data and up_out_data to 0.
REQ-027 Reset mid-operation SHALL discard all buffered and in-flight flits. After release, loc_in_ready=4'hF and up_in_ready=1.

Structure
REQ-028 A shared package SHALL hold the header field positions, NUM_PORTS=5, UP_PORT=4 and INVALID_GROUP=0.
REQ-029 The FIFO SHALL be a sub-module flit_fifo, instantiated 5 times; routing and arbitration SHALL stay in leaf_switch.

Verification
REQ-030 Single local flit 0x1C05 on port 0 -> loc_out_valid[3] pulses once with data 0x1C05 after edge E+1; drop_count stays 0.
REQ-031 Port 1 sends 0x2012 (group 2) with up_out_ready=0 for 5 cycles -> up_out_data holds 0x2012 and valid stays 1, then one transfer occurs when ready rises.
REQ-032 Ports 0, 1 and 2 send to leaf 2 (0x1800) in the same cycle -> three pulses on loc_out_valid[2] in input order 0,1,2 on consecutive cycles.
REQ-033 Uplink sends 0x3000 and 0x0005 -> both dropped, drop_count=2, no output valid.
REQ-034 Burst of 6 flits on port 0 while output 3 is contended by ports 1-2 -> loc_in_ready[0] falls when 1 slot is left, no flit is lost, drop_count=0.
REQ-035 reset asserted with 3 flits buffered -> all outputs 0 immediately; no stale flit emerges after release.
